// File: rtl/irq_controller_if.sv
// ---------------------------------------------------------------------------
// irq_controller_if
// Bus between the interrupt controller and the CPU core.
//   mask_wr, mask_din  : core loads the source mask (1 = masked)
//   ei, di, eoi        : one-cycle pulses from EI, DI and return-from-interrupt
//   irq_ack            : core accepts the presented vector at an instruction boundary
//   irq_req, irq_vec   : request and jump target presented to the core
//   ien                : global interrupt enable flag
//   mask, pending      : current mask register and latched requests
//   in_service         : one-hot source being serviced, 0 when none
// Modports: master = core side, slave = controller side.
// ---------------------------------------------------------------------------
interface irq_controller_if #(
    parameter int NUM_SRC = 4
);
    logic               mask_wr;
    logic [NUM_SRC-1:0] mask_din;
    logic               ei;
    logic               di;
    logic               eoi;
    logic               irq_ack;
    logic               irq_req;
    logic [7:0]         irq_vec;
    logic               ien;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;

    modport master (
        output mask_wr, mask_din, ei, di, eoi, irq_ack,
        input  irq_req, irq_vec, ien, mask, pending, in_service
    );

    modport slave (
        input  mask_wr, mask_din, ei, di, eoi, irq_ack,
        output irq_req, irq_vec, ien, mask, pending, in_service
    );
endinterface

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
// Prioritised interrupt controller for the 8-bit matrix CPU. Raw active-low
// buttons are synchronised, debounced and edge-detected into pending bits;
// the lowest-index unmasked pending source is presented to the core with a
// req/ack handshake and tracked as in-service until end of interrupt.
// Ports:
//   clock    : system clock, rising edge
//   rst      : asynchronous, active-low reset
//   src_n_i  : raw button inputs, active-low, asynchronous
//   bus      : core-facing bus (irq_controller_if.slave)
// ---------------------------------------------------------------------------
module irq_controller #(
    parameter int NUM_SRC    = 4,
    parameter int DB_CYCLES  = 3,
    parameter int VEC_BASE   = 2,
    parameter int VEC_STRIDE = 2
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_n_i,
    irq_controller_if.slave    bus
);

    localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    logic [NUM_SRC-1:0]      sync1_q, sync2_q;
    logic [NUM_SRC-1:0]      level_q, level_d, levelPrev_q;
    logic [NUM_SRC-1:0][3:0] cnt_q, cnt_d;
    logic [NUM_SRC-1:0]      pending_q, pending_d;
    logic [NUM_SRC-1:0]      mask_q, mask_d;
    logic [NUM_SRC-1:0]      rise, eligible, ackClr;
    logic [NUM_SRC-1:0]      inService_q;
    logic [IDW-1:0]          id_q, winner;
    state_t                  state_q;
    logic                    irqReq_q;
    logic [7:0]              irqVec_q;
    logic                    ien_q;
    logic                    ackNow;
    logic                    withdraw;

    // Jump target of a source, wrapped to the 8-bit address space.
    function automatic logic [7:0] vecOf(input logic [IDW-1:0] id);
        logic [31:0] v;
        v = 32'(VEC_BASE) + 32'(id) * 32'(VEC_STRIDE);
        return v[7:0];
    endfunction

    // Debounce: a level flips only after DB_CYCLES consecutive disagreeing
    // synchronised samples; any agreeing sample restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (~sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] + 4'd1 == 4'(DB_CYCLES)) begin
                    level_d[i] = ~level_q[i];
                    cnt_d[i]   = 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end else begin
                cnt_d[i] = 4'd0;
            end
        end
    end

    // Pending bookkeeping: the ack clears only the old request, so a rising
    // edge landing in the same cycle still re-arms the source.
    always_comb begin
        rise      = level_q & ~levelPrev_q;
        ackNow    = (state_q == REQ) && bus.irq_ack;
        ackClr    = ackNow ? (NUM_SRC'(1) << id_q) : '0;
        pending_d = (pending_q & ~ackClr) | rise;
        mask_d    = bus.mask_wr ? bus.mask_din : mask_q;
        eligible  = pending_q & ~mask_q;
        withdraw  = mask_d[id_q] || bus.di;
    end

    // Priority encoder: lowest index wins, so scan downwards.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = IDW'(i);
            end
        end
    end

    // Input datapath: synchroniser, debounce state and pending/mask registers.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            level_q     <= '0;
            levelPrev_q <= '0;
            cnt_q       <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
        end else begin
            sync1_q     <= src_n_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            levelPrev_q <= level_q;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
        end
    end

    // Request/service FSM with registered outputs. The vector is latched on
    // entry to REQ so a later higher-priority press cannot disturb it; ei/di
    // are ignored while a source is in service.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            id_q        <= '0;
            irqReq_q    <= 1'b0;
            irqVec_q    <= 8'd0;
            ien_q       <= 1'b0;
            inService_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    irqReq_q <= 1'b0;
                    if (bus.di) begin
                        ien_q <= 1'b0;
                    end else if (bus.ei) begin
                        ien_q <= 1'b1;
                    end
                    if (ien_q && (eligible != '0)) begin
                        id_q     <= winner;
                        irqVec_q <= vecOf(winner);
                        irqReq_q <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (bus.irq_ack) begin
                        inService_q <= NUM_SRC'(1) << id_q;
                        ien_q       <= 1'b0;
                        irqReq_q    <= 1'b0;
                        state_q     <= SERVICE;
                    end else begin
                        if (bus.di) begin
                            ien_q <= 1'b0;
                        end else if (bus.ei) begin
                            ien_q <= 1'b1;
                        end
                        if (withdraw) begin
                            irqReq_q <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end
                end
                SERVICE: begin
                    irqReq_q <= 1'b0;
                    if (bus.eoi) begin
                        inService_q <= '0;
                        ien_q       <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.irq_req    = irqReq_q;
    assign bus.irq_vec    = irqVec_q;
    assign bus.ien        = ien_q;
    assign bus.mask       = mask_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = inService_q;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritised interrupt controller for the 8-bit matrix CPU.
- Turns raw active-low button inputs into interrupt requests: synchronises, debounces, edge-detects and latches each source as pending, then arbitrates.
- Presents one vector at a time to the CPU core with a req/ack handshake, tracks the in-service source, and owns the global interrupt-enable flag.
- Sits between the button pins and the core's instruction-boundary fetch logic. The core drives ei/di/eoi from the EI, DI and return-from-interrupt instructions.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..8)
DB_CYCLES, 3, consecutive equal synchronised samples needed to change a debounced level (1..15)
VEC_BASE, 2, vector (jump target) of source 0
VEC_STRIDE, 2, vector spacing between sources

Ports:
clock  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
src_n  in  NUM_SRC  raw button inputs, active-low, asynchronous
mask_wr  in  1  load mask from mask_din this cycle
mask_din  in  NUM_SRC  new mask value, 1 = source masked
ei  in  1  one-cycle pulse, set ien
di  in  1  one-cycle pulse, clear ien
eoi  in  1  one-cycle pulse, end of interrupt service
irq_ack  in  1  core accepts the presented vector (instruction boundary)
irq_req  out  1  interrupt request to core
irq_vec  out  8  vector for current request
ien  out  1  global interrupt enable
mask  out  NUM_SRC  current mask register
pending  out  NUM_SRC  latched, not-yet-acknowledged sources
in_service  out  NUM_SRC  one-hot source being serviced, 0 when none

Behaviour:
- Reset (async, rst=0):
  - synchroniser flops = all 1 (released);
  - debounced levels = 0;
  - debounce counters = 0;
  - pending, in_service, mask = 0;
  - ien = 0;
  - irq_req = 0, irq_vec = 0;
  - state = IDLE.
  - Reset mid-request or mid-service aborts immediately to these values.
- Synchroniser: two flops per source; sample s = ~sync2.
- Debounce, per source:
  - If s != debounced level, counter increments. On the edge where it reaches DB_CYCLES, the level flips and the counter clears.
  - If s == level, counter clears.
- Edge detect: debounced rising edge sets pending[i] on the next edge. A rise while pending[i] is already 1 is absorbed (no counting). Falling edges are ignored.
- Latency: a press stable from edge 1 gives pending at edge 2+DB_CYCLES+1 and irq_req at the following edge (7 edges for DB_CYCLES=3).
- Eligible set = pending & ~mask. Priority: lowest index wins.
- State IDLE:
  - irq_req = 0.
  - If ien && eligible != 0, latch the winner id, then go to REQ with irq_req = 1 and irq_vec = (VEC_BASE + id*VEC_STRIDE) mod 256, registered.
- State REQ:
  - irq_req and irq_vec are held stable; a newly pending higher-priority source does not change them.
  - On irq_ack: clear pending[id], set in_service = 1<<id, ien = 0, irq_req = 0, go to SERVICE.
  - Withdrawal: if, before ack, mask[id] becomes 1 or di arrives, drop irq_req next edge, go to IDLE, and keep pending[id].
  - If irq_ack and the withdrawal cause occur in the same cycle, irq_ack wins.
- State SERVICE:
  - irq_req = 0; no arbitration (no nesting).
  - On eoi: in_service = 0, ien = 1, go to IDLE.
  - New presses still set pending during SERVICE.
- ei/di:
  - Take effect in any state except SERVICE, where they are ignored (ien stays 0 until eoi).
  - ei and di in the same cycle: di wins.
- Ignored events: irq_ack outside REQ; eoi outside SERVICE.
- mask_wr: takes effect any state, on the next edge. mask_wr in the same cycle as irq_ack does not cancel the ack.
- Same-edge interaction: pending set by a new edge in the same cycle as its ack clear → the ack clear wins only for the acknowledged source's old request; a new rising edge in that cycle re-sets pending.

Test Plan:
- Reset, ei pulse, src_n[2] low held 10 clocks → pending=4'b0100 at edge 6; irq_req=1, irq_vec=6 at edge 7; irq_ack → in_service=4'b0100, pending=0, ien=0; eoi → ien=1, in_service=0, state IDLE.
- src_n[1] glitch low 2 clocks (DB_CYCLES=3) → debounced level, pending and irq_req stay 0.
- src_n[3] and src_n[0] pressed together, ien=1 → irq_vec=2. After ack+eoi a second request follows with irq_vec=8.
- During REQ for source 2, press source 0 → irq_vec stays 6 until ack. After eoi a request follows with irq_vec=2.
- Mask: mask_din=4'b0100, mask_wr during REQ for source 2 → irq_req falls next edge, pending[2] stays 1. Unmask → irq_req with irq_vec=6 returns.
- ei+di same cycle → ien=0. Async rst low during SERVICE → all outputs 0 immediately, ien=0.
